// File: rtl/parity_frame_rx.sv
// ============================================================================
// parity_frame_rx : serial start/data/parity/stop frame receiver with
//                   XOR parity check and framing-error detection.
// Revision 1.0
// ============================================================================
`default_nettype none

module parity_frame_rx #(
  parameter int DATA_W     = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              rx_bit,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              acc_q, acc_d;
  logic              perr_q, perr_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q, frame_err_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    acc_d        = acc_q;
    perr_d       = perr_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;

    if (en) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_bit) begin
            state_d = S_DATA;
            cnt_d   = '0;
            acc_d   = 1'b0;
          end
        end
        S_DATA: begin
          // Right shift so the first bit received lands in bit 0.
          shift_d = {rx_bit, shift_q[DATA_W-1:1]};
          acc_d   = acc_q ^ rx_bit;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = S_PARITY;
          end
        end
        S_PARITY: begin
          perr_d  = acc_q ^ rx_bit ^ PARITY_ODD;
          state_d = S_STOP;
        end
        S_STOP: begin
          if (rx_bit) begin
            data_out_d   = shift_q;
            data_valid_d = 1'b1;
            parity_err_d = perr_q;
          end else begin
            frame_err_d  = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      acc_q        <= 1'b0;
      perr_q       <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      acc_q        <= acc_d;
      perr_q       <= perr_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_parity_frame_rx.sv
// ============================================================================
// tb_parity_frame_rx : directed bench for parity_frame_rx (even and odd DUTs).
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_parity_frame_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       rx_bit = 1'b1;

  logic [7:0] e_data, o_data;
  logic       e_dv, e_pe, e_fe, e_busy;
  logic       o_dv, o_pe, o_fe, o_busy;

  int n_checks = 0;
  int n_errors = 0;
  int e_dv_cnt = 0;
  int e_fe_cnt = 0;
  int exp_dv   = 0;
  int exp_fe   = 0;

  always #5 clk = ~clk;

  parity_frame_rx #(.DATA_W(8), .PARITY_ODD(1'b0)) u_even (
    .clk(clk), .rst(rst), .en(en), .rx_bit(rx_bit),
    .data_out(e_data), .data_valid(e_dv), .parity_err(e_pe),
    .frame_err(e_fe), .busy(e_busy)
  );

  parity_frame_rx #(.DATA_W(8), .PARITY_ODD(1'b1)) u_odd (
    .clk(clk), .rst(rst), .en(en), .rx_bit(rx_bit),
    .data_out(o_data), .data_valid(o_dv), .parity_err(o_pe),
    .frame_err(o_fe), .busy(o_busy)
  );

  // Pulse counters catch spurious or missing status pulses between checks.
  always @(negedge clk) begin
    if (e_dv) e_dv_cnt++;
    if (e_fe) e_fe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One strobe, then `gap` cycles with en low and the line deliberately toggled.
  task automatic send_bit(input logic b, input int gap);
    rx_bit = b;
    en     = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    for (int i = 0; i < gap; i++) begin
      rx_bit = ~rx_bit;
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the caller at #1 after the stop-strobe edge (gap=0) so status is visible.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int gap);
    send_bit(1'b0, gap);
    for (int i = 0; i < 8; i++) send_bit(d[i], gap);
    send_bit(p, gap);
    check("dv_low_before_stop", {31'd0, e_dv}, 32'd0);
    send_bit(s, 0);
  endtask

  initial begin
    idle_cycles(3);
    check("rst_data", {24'd0, e_data}, 32'd0);
    check("rst_flags", {28'd0, e_dv, e_pe, e_fe, e_busy}, 32'd0);
    check("rst_odd_flags", {28'd0, o_dv, o_pe, o_fe, o_busy}, 32'd0);
    rst = 1'b0;
    idle_cycles(2);

    // Good frame 0xA5, even parity 0
    send_bit(1'b0, 0);
    check("busy_after_start", {31'd0, e_busy}, 32'd1);
    for (int i = 0; i < 8; i++) send_bit(((8'hA5 >> i) & 8'h01) != 0, 0);
    send_bit(1'b0, 0);
    check("dv_low_at_parity", {31'd0, e_dv}, 32'd0);
    send_bit(1'b1, 0);
    check("good_dv", {31'd0, e_dv}, 32'd1);
    check("good_data", {24'd0, e_data}, 32'hA5);
    check("good_pe", {31'd0, e_pe}, 32'd0);
    check("good_fe", {31'd0, e_fe}, 32'd0);
    check("good_busy_fall", {31'd0, e_busy}, 32'd0);
    exp_dv++;
    idle_cycles(1);
    check("dv_one_cycle", {31'd0, e_dv}, 32'd0);

    // Parity error
    send_frame(8'hA5, 1'b1, 1'b1, 0);
    check("perr_dv", {31'd0, e_dv}, 32'd1);
    check("perr_pe", {31'd0, e_pe}, 32'd1);
    check("perr_data", {24'd0, e_data}, 32'hA5);
    exp_dv++;
    idle_cycles(1);
    check("pe_one_cycle", {31'd0, e_pe}, 32'd0);

    // Frame error: 0x3C, parity 0, stop 0
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    check("ferr_fe", {31'd0, e_fe}, 32'd1);
    check("ferr_dv", {31'd0, e_dv}, 32'd0);
    check("ferr_pe", {31'd0, e_pe}, 32'd0);
    check("ferr_data_kept", {24'd0, e_data}, 32'hA5);
    exp_fe++;
    rx_bit = 1'b1;
    idle_cycles(1);
    check("fe_one_cycle", {31'd0, e_fe}, 32'd0);

    // Sparse strobes with line glitches while en is low
    send_frame(8'h01, 1'b1, 1'b1, 3);
    check("sparse_dv", {31'd0, e_dv}, 32'd1);
    check("sparse_data", {24'd0, e_data}, 32'h01);
    check("sparse_pe", {31'd0, e_pe}, 32'd0);
    check("sparse_odd_pe", {31'd0, o_pe}, 32'd1);
    exp_dv++;
    rx_bit = 1'b1;
    idle_cycles(2);

    // Back-to-back frames: next start bit on the strobe right after stop
    send_frame(8'hFF, 1'b0, 1'b1, 0);
    check("b2b1_dv", {31'd0, e_dv}, 32'd1);
    check("b2b1_data", {24'd0, e_data}, 32'hFF);
    check("b2b1_pe", {31'd0, e_pe}, 32'd0);
    exp_dv++;
    send_frame(8'h80, 1'b1, 1'b1, 0);
    check("b2b2_dv", {31'd0, e_dv}, 32'd1);
    check("b2b2_data", {24'd0, e_data}, 32'h80);
    check("b2b2_pe", {31'd0, e_pe}, 32'd0);
    exp_dv++;
    rx_bit = 1'b1;
    idle_cycles(2);

    // Reset after 4 data bits of an aborted frame
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    rst = 1'b1;
    en  = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    en  = 1'b0;
    check("midrst_data", {24'd0, e_data}, 32'd0);
    check("midrst_flags", {28'd0, e_dv, e_pe, e_fe, e_busy}, 32'd0);
    idle_cycles(2);
    send_frame(8'h5A, 1'b0, 1'b1, 0);
    check("after_rst_dv", {31'd0, e_dv}, 32'd1);
    check("after_rst_data", {24'd0, e_data}, 32'h5A);
    check("after_rst_pe", {31'd0, e_pe}, 32'd0);
    exp_dv++;
    idle_cycles(2);

    // Odd-parity DUT
    send_frame(8'h00, 1'b1, 1'b1, 0);
    check("odd_ok_dv", {31'd0, o_dv}, 32'd1);
    check("odd_ok_pe", {31'd0, o_pe}, 32'd0);
    check("odd_ok_data", {24'd0, o_data}, 32'h00);
    check("even_sees_perr", {31'd0, e_pe}, 32'd1);
    exp_dv++;
    idle_cycles(1);
    send_frame(8'h00, 1'b0, 1'b1, 0);
    check("odd_bad_dv", {31'd0, o_dv}, 32'd1);
    check("odd_bad_pe", {31'd0, o_pe}, 32'd1);
    check("even_no_perr", {31'd0, e_pe}, 32'd0);
    exp_dv++;
    idle_cycles(3);

    check("dv_pulse_count", e_dv_cnt, exp_dv);
    check("fe_pulse_count", e_fe_cnt, exp_fe);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
